// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the main decoder.
//   Holds the PC and issues one word request at a time to instruction memory.
//   It captures the returned word and presents it, with its PC and PC+4, to
//   decode under a valid/ready handshake.
//   Redirects replace the fetch PC. A response that is still in flight when a
//   redirect arrives is drained and discarded.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect
//   targets into a sticky FAULT state. When it is not defined, the low two
//   bits of a redirect target are forced to zero.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   imem_req, imem_addr      request pulse / word address to instruction memory
//   imem_rvalid, imem_rdata  response strobe / instruction word from memory
//   instr, instr_pc,
//   instr_pc_plus4           captured instruction, its PC, and that PC + 4
//   instr_valid, instr_ready handshake with decode
//   redirect,
//   redirect_target          PC redirect from branch/jump resolution
//   fetch_fault              sticky misaligned-redirect fault
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            fetch_fault
);

  typedef enum logic [2:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
`ifdef FETCH_ALIGN_CHECK_EN
    , ST_FAULT
`endif
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic [XLEN-1:0] r_instr_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_redirect;
  logic            w_misaligned;

  // Word-aligned redirect target. When the alignment check is enabled,
  // misaligned targets never load, so the mask has no effect in that build.
  assign w_target = redirect_target & ~XLEN'(3);

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;
  assign w_misaligned = |redirect_target[1:0];
  assign w_redirect   = redirect && (r_state != ST_FAULT);
  assign fetch_fault  = r_fault;
`else
  assign w_misaligned = 1'b0;
  assign w_redirect   = redirect;
  assign fetch_fault  = 1'b0;
`endif

  assign imem_req       = (r_state == ST_ISSUE);
  assign imem_addr      = r_pc;
  assign instr_valid    = (r_state == ST_HOLD);
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_pc_plus4 = r_instr_pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_ISSUE;
      r_pc             <= RESET_PC;
      r_instr          <= '0;
      r_instr_pc       <= '0;
      r_instr_pc_plus4 <= XLEN'(4);
`ifdef FETCH_ALIGN_CHECK_EN
      r_fault          <= 1'b0;
`endif
    end else if (w_redirect && w_misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
      r_state <= ST_FAULT;
      r_fault <= 1'b1;
`endif
    end else if (w_redirect) begin
      // A request is still outstanding after ISSUE, and after WAIT/DRAIN
      // without a response. Drain it before issuing to the new PC.
      r_pc <= w_target;
      case (r_state)
        ST_ISSUE: r_state <= ST_DRAIN;
        ST_WAIT:  r_state <= imem_rvalid ? ST_ISSUE : ST_DRAIN;
        ST_DRAIN: r_state <= imem_rvalid ? ST_ISSUE : ST_DRAIN;
        default:  r_state <= ST_ISSUE;
      endcase
    end else begin
      case (r_state)
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid) begin
            r_instr          <= imem_rdata;
            r_instr_pc       <= r_pc;
            r_instr_pc_plus4 <= r_pc + XLEN'(4);
            r_state          <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            r_pc    <= r_pc + XLEN'(4);
            r_state <= ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) r_state <= ST_ISSUE;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        ST_FAULT: r_state <= ST_FAULT;
`endif
        default: r_state <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_fault;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_target = '0;
    step(); step();
    chk("rst_instr",  instr, 32'h0);
    chk("rst_pc",     instr_pc, 32'h0);
    chk("rst_pc4",    instr_pc_plus4, 32'h4);
    chk("rst_valid",  {31'b0, instr_valid}, 32'h0);
    chk("rst_addr",   imem_addr, 32'h0);
    chk("rst_fault",  {31'b0, fetch_fault}, 32'h0);

    // L=1, ready tied 1: requests on cycles 0,3,6; valid on 2,5,8.
    reset = 1'b0; instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("l1_req",   {31'b0, imem_req}, 32'h1);
      chk("l1_addr",  imem_addr, 32'(4 * k));
      step();
      chk("l1_noreq", {31'b0, imem_req}, 32'h0);
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
      step();
      imem_rvalid = 1'b0;
      chk("l1_valid", {31'b0, instr_valid}, 32'h1);
      chk("l1_ipc",   instr_pc, 32'(4 * k));
      chk("l1_instr", instr, 32'h0000_0013);
      step();
    end

    // L=3 with decode stalled 4 cycles; a stray strobe in HOLD is ignored.
    instr_ready = 1'b0;
    chk("l3_addr", imem_addr, 32'hC);
    step(); step(); step();
    imem_rvalid = 1'b1; imem_rdata = 32'hAABB_CC93;
    step();
    imem_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("hold_valid", {31'b0, instr_valid}, 32'h1);
      chk("hold_instr", instr, 32'hAABB_CC93);
      chk("hold_ipc",   instr_pc, 32'hC);
      chk("hold_noreq", {31'b0, imem_req}, 32'h0);
      imem_rvalid = (k == 1); imem_rdata = 32'hFFFF_FFFF;
      step();
    end
    imem_rvalid = 1'b0;
    chk("hold_after", instr, 32'hAABB_CC93);
    instr_ready = 1'b1;
    step();
    chk("acc_addr", imem_addr, 32'h10);
    chk("acc_req",  {31'b0, imem_req}, 32'h1);

    // Redirect to 0x100 in WAIT; the stale response arrives two cycles later.
    step();
    redirect = 1'b1; redirect_target = 32'h100;
    step();
    redirect = 1'b0;
    chk("drain_valid", {31'b0, instr_valid}, 32'h0);
    chk("drain_noreq", {31'b0, imem_req}, 32'h0);
    step();
    chk("drain_noreq2", {31'b0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("rd1_req",  {31'b0, imem_req}, 32'h1);
    chk("rd1_addr", imem_addr, 32'h100);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    chk("rd1_ipc",   instr_pc, 32'h100);
    chk("rd1_instr", instr, 32'h0050_0093);
    chk("rd1_pc4",   instr_pc_plus4, 32'h104);
    step();
    chk("rd1_next", imem_addr, 32'h104);

    // Redirect to 0x200 coincident with a response in WAIT.
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    redirect = 1'b1; redirect_target = 32'h200;
    step();
    imem_rvalid = 1'b0; redirect = 1'b0;
    chk("rd2_valid", {31'b0, instr_valid}, 32'h0);
    chk("rd2_addr",  imem_addr, 32'h200);
    chk("rd2_req",   {31'b0, imem_req}, 32'h1);
    chk("rd2_instr", instr, 32'h0050_0093);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0011;
    step();
    imem_rvalid = 1'b0;
    chk("rd2_ipc", instr_pc, 32'h200);
    // Redirect in HOLD together with instr_ready: no pc+4.
    redirect = 1'b1; redirect_target = 32'h300;
    step();
    redirect = 1'b0;
    chk("rd3_addr",  imem_addr, 32'h300);
    chk("rd3_valid", {31'b0, instr_valid}, 32'h0);

    // Redirect in ISSUE to the top word, then the PC wraps to 0.
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("iss_drain", {31'b0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_rvalid = 1'b0;
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", instr_pc_plus4, 32'h0);
    step();
    chk("wrap_next", imem_addr, 32'h0);

    // Misaligned redirect to 0x102 issued from ISSUE.
    redirect = 1'b1; redirect_target = 32'h102;
    step();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      chk("flt_fault", {31'b0, fetch_fault}, 32'h1);
      chk("flt_noreq", {31'b0, imem_req}, 32'h0);
      chk("flt_valid", {31'b0, instr_valid}, 32'h0);
      imem_rvalid = (k == 0); imem_rdata = 32'h0;
      step();
    end
    imem_rvalid = 1'b0;
    chk("flt_addr", imem_addr, 32'h0);
`else
    chk("mis_fault", {31'b0, fetch_fault}, 32'h0);
    chk("mis_noreq", {31'b0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0;
    step();
    imem_rvalid = 1'b0;
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_req",  {31'b0, imem_req}, 32'h1);
    step();
`endif

    // Reset with a request in flight restores all reset values.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_instr", instr, 32'h0);
    chk("rst2_pc",    instr_pc, 32'h0);
    chk("rst2_pc4",   instr_pc_plus4, 32'h4);
    chk("rst2_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst2_addr",  imem_addr, 32'h0);
    chk("rst2_fault", {31'b0, fetch_fault}, 32'h0);
    chk("rst2_req",   {31'b0, imem_req}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
